// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// Digit maxima, digit-select encodings and the BCD wrap helper live here.
package stopwatch_pkg;

  typedef enum logic [0:0] {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;

  localparam logic [1:0] SEL_SEC_ONES = 2'd0;
  localparam logic [1:0] SEL_SEC_TENS = 2'd1;
  localparam logic [1:0] SEL_MIN_ONES = 2'd2;
  localparam logic [1:0] SEL_MIN_TENS = 2'd3;

  // ">=" keeps the digit legal even if it ever held a value above its maximum.
  function automatic logic [3:0] bcd_wrap_inc(input logic [3:0] d, input logic [3:0] max);
    logic [3:0] r;
    if (d >= max) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_at_max(input logic [3:0] d, input logic [3:0] max);
    return (d >= max);
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-count debouncer and
// a one-clk pulse on each rising edge of the debounced level.
module btn_cond #(
  parameter int unsigned DB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The level flips on the DB_CYCLES-th consecutive sample that differs from it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button conditioning, run/pause FSM,
// cascaded BCD MM:SS counter and per-digit adjust with blink phase.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = 65536,
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sw_adj,
  input  logic [1:0] sw_sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       adj,
  output logic [1:0] sel,
  output logic       blink,
  output logic       running,
  output logic       rollover
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);

  logic       pause_p;
  logic       clr_p;

  logic       adj_s1_q, adj_s2_q, adj_q;
  logic [1:0] sel_s1_q, sel_s2_q, sel_q;

  state_e     state_q, state_d;
  logic [3:0] mt_q, mt_d;
  logic [3:0] mo_q, mo_d;
  logic [3:0] st_q, st_d;
  logic [3:0] so_q, so_d;
  logic       blink_q, blink_d;
  logic       rollover_q, rollover_d;

  btn_cond #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_pause),
    .pulse (pause_p)
  );

  btn_cond #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  // Switches are level controls read by a human; synchronizing is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_s1_q <= 1'b0;
      adj_s2_q <= 1'b0;
      adj_q    <= 1'b0;
      sel_s1_q <= 2'd0;
      sel_s2_q <= 2'd0;
      sel_q    <= 2'd0;
    end else begin
      adj_s1_q <= sw_adj;
      adj_s2_q <= adj_s1_q;
      adj_q    <= adj_s2_q;
      sel_s1_q <= sw_sel;
      sel_s2_q <= sel_s1_q;
      sel_q    <= sel_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pause_p) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end
  end

  // Clear beats adjust, adjust beats counting.
  always_comb begin
    mt_d       = mt_q;
    mo_d       = mo_q;
    st_d       = st_q;
    so_d       = so_q;
    rollover_d = 1'b0;
    if (clr_p) begin
      mt_d = 4'd0;
      mo_d = 4'd0;
      st_d = 4'd0;
      so_d = 4'd0;
    end else if (adj_q) begin
      if (tick_2hz) begin
        unique case (sel_q)
          SEL_SEC_ONES: so_d = bcd_wrap_inc(so_q, SEC_ONES_MAX);
          SEL_SEC_TENS: st_d = bcd_wrap_inc(st_q, SEC_TENS_MAX);
          SEL_MIN_ONES: mo_d = bcd_wrap_inc(mo_q, MIN_ONES_MAX);
          SEL_MIN_TENS: mt_d = bcd_wrap_inc(mt_q, MIN_TENS_MAX);
          default:      so_d = so_q;
        endcase
      end
    end else if ((state_q == RUN) && tick_1hz) begin
      so_d = bcd_wrap_inc(so_q, SEC_ONES_MAX);
      if (bcd_at_max(so_q, SEC_ONES_MAX)) begin
        st_d = bcd_wrap_inc(st_q, SEC_TENS_MAX);
        if (bcd_at_max(st_q, SEC_TENS_MAX)) begin
          mo_d = bcd_wrap_inc(mo_q, MIN_ONES_MAX);
          if (bcd_at_max(mo_q, MIN_ONES_MAX)) begin
            mt_d = bcd_wrap_inc(mt_q, MIN_TENS_MAX);
            rollover_d = bcd_at_max(mt_q, MIN_TENS_MAX);
          end
        end
      end
    end
  end

  always_comb begin
    blink_d = 1'b0;
    if (adj_q) begin
      blink_d = tick_2hz ? ~blink_q : blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAUSED;
      mt_q       <= 4'd0;
      mo_q       <= 4'd0;
      st_q       <= 4'd0;
      so_q       <= 4'd0;
      blink_q    <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mt_q       <= mt_d;
      mo_q       <= mo_d;
      st_q       <= st_d;
      so_q       <= so_d;
      blink_q    <= blink_d;
      rollover_q <= rollover_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign adj      = adj_q;
  assign sel      = sel_q;
  assign blink    = blink_q;
  assign running  = (state_q == RUN);
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clr = 1'b0;
  logic       sw_adj = 1'b0;
  logic [1:0] sw_sel = 2'd0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       adj;
  logic [1:0] sel;
  logic       blink;
  logic       running;
  logic       rollover;
  logic [15:0] digits;

  int checks = 0;
  int failures = 0;
  int ro_count = 0;

  stopwatch_ctrl #(
    .DB_CYCLES    (4),
    .MAX_MIN_TENS (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .btn_pause (btn_pause),
    .btn_clr   (btn_clr),
    .sw_adj    (sw_adj),
    .sw_sel    (sw_sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .adj       (adj),
    .sel       (sel),
    .blink     (blink),
    .running   (running),
    .rollover  (rollover)
  );

  always #5 clk = ~clk;

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  always @(negedge clk) begin
    if (rst_n && rollover) ro_count <= ro_count + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick1;
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
  endtask

  task automatic tick2;
    @(negedge clk) tick_2hz = 1'b1;
    @(negedge clk) tick_2hz = 1'b0;
  endtask

  task automatic press_clr;
    @(negedge clk) btn_clr = 1'b1;
    cycles(10);
    btn_clr = 1'b0;
    cycles(10);
  endtask

  // Loads MM:SS from 00:00 through the adjust path, then leaves adjust mode.
  task automatic set_time(input int mt, input int mo, input int st, input int so);
    int n[4];
    n[0] = so; n[1] = st; n[2] = mo; n[3] = mt;
    @(negedge clk) sw_adj = 1'b1;
    cycles(4);
    for (int d = 0; d < 4; d++) begin
      sw_sel = 2'(d);
      cycles(4);
      for (int k = 0; k < n[d]; k++) tick2();
    end
    sw_adj = 1'b0;
    sw_sel = 2'd0;
    cycles(4);
  endtask

  initial begin
    int toggles;
    int ro_before;
    logic b0;

    #1 rst_n = 1'b0;
    #2;
    check_eq("reset_digits", 32'(digits), 32'h0);
    check_eq("reset_running", 32'(running), 32'h0);
    check_eq("reset_adj_sel_blink", 32'({adj, sel, blink}), 32'h0);
    check_eq("reset_rollover", 32'(rollover), 32'h0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);

    // 3-clk glitch must be swallowed by the debouncer
    @(negedge clk) btn_pause = 1'b1;
    cycles(3);
    btn_pause = 1'b0;
    cycles(12);
    check_eq("glitch_no_toggle", 32'(running), 32'h0);

    // Held press toggles on the 7th edge after the press
    @(negedge clk) btn_pause = 1'b1;
    cycles(6);
    check_eq("press_before_7", 32'(running), 32'h0);
    cycles(1);
    check_eq("press_at_7", 32'(running), 32'h1);
    cycles(3);
    btn_pause = 1'b0;
    cycles(12);
    check_eq("press_single_toggle", 32'(running), 32'h1);

    // Run 75 seconds
    ro_before = ro_count;
    for (int i = 0; i < 10; i++) tick1();
    check_eq("run_10s", 32'(digits), 32'h0010);
    for (int i = 0; i < 65; i++) tick1();
    check_eq("run_75s", 32'(digits), 32'h0115);
    check_eq("run_no_rollover", 32'(ro_count - ro_before), 32'h0);

    press_clr();
    check_eq("clear_plain", 32'(digits), 32'h0);
    check_eq("clear_keeps_run", 32'(running), 32'h1);

    // Adjust sec_tens 7 times with 1 Hz ticks also present
    @(negedge clk) sw_adj = 1'b1;
    sw_sel = 2'd1;
    cycles(4);
    check_eq("adj_sync", 32'({adj, sel}), 32'h5);
    toggles = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) b0 = blink;
      tick_2hz = 1'b1;
      tick_1hz = 1'b1;
      @(negedge clk) tick_2hz = 1'b0;
      tick_1hz = 1'b0;
      if (blink != b0) toggles++;
    end
    check_eq("adj_digits", 32'(digits), 32'h0010);
    check_eq("adj_blink_toggles", 32'(toggles), 32'd7);
    check_eq("adj_blink_phase", 32'(blink), 32'h1);
    sw_adj = 1'b0;
    cycles(4);
    check_eq("adj_exit_blink", 32'(blink), 32'h0);

    press_clr();
    set_time(1, 2, 3, 4);
    check_eq("preload_1234", 32'(digits), 32'h1234);

    // Clear pulse lands in the same cycle as a 1 Hz tick
    @(negedge clk) btn_clr = 1'b1;
    cycles(6);
    tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    check_eq("clr_beats_tick", 32'(digits), 32'h0);
    check_eq("clr_keeps_running", 32'(running), 32'h1);
    cycles(4);
    btn_clr = 1'b0;
    cycles(10);

    // Rollover 59:58 -> 59:59 -> 00:00
    set_time(5, 9, 5, 8);
    check_eq("preload_5958", 32'(digits), 32'h5958);
    ro_before = ro_count;
    tick1();
    check_eq("roll_5959", 32'(digits), 32'h5959);
    check_eq("roll_not_yet", 32'(rollover), 32'h0);
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    check_eq("roll_0000", 32'(digits), 32'h0);
    check_eq("roll_pulse", 32'(rollover), 32'h1);
    cycles(1);
    check_eq("roll_one_clk", 32'(rollover), 32'h0);
    check_eq("roll_count", 32'(ro_count - ro_before), 32'h1);

    // Asynchronous reset in the middle of adjust
    @(negedge clk) sw_adj = 1'b1;
    sw_sel = 2'd2;
    cycles(4);
    for (int i = 0; i < 3; i++) tick2();
    check_eq("pre_rst_digits", 32'(digits), 32'h0300);
    check_eq("pre_rst_blink", 32'(blink), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_digits", 32'(digits), 32'h0);
    check_eq("async_rst_flags", 32'({adj, sel, blink, running, rollover}), 32'h0);
    sw_adj = 1'b0;
    sw_sel = 2'd0;
    cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick1();
    check_eq("post_rst_paused", 32'(running), 32'h0);
    check_eq("post_rst_digits", 32'(digits), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
